// File: rtl/fifo_wr_ctrl_if.sv
// Write-port bundle of the async FIFO write controller.
// master: producer / read-domain side that drives requests and the read
// pointer. slave: the write controller itself.
// almost_full exists only when FIFO_WR_ALMOST_FULL_EN is defined.
interface fifo_wr_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              wr_req;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W:0]   rd_ptr_gray;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] d_in;
  logic [ADDR_W:0]   wr_ptr_gray;
  logic              full;
  logic [ADDR_W:0]   wr_count;
  logic              overflow;
`ifdef FIFO_WR_ALMOST_FULL_EN
  logic              almost_full;
`endif

  modport master (
    output wr_req, wr_data, rd_ptr_gray,
    input  wr_en, wr_addr, d_in, wr_ptr_gray, full, wr_count, overflow
`ifdef FIFO_WR_ALMOST_FULL_EN
    , input almost_full
`endif
  );

  modport slave (
    input  wr_req, wr_data, rd_ptr_gray,
    output wr_en, wr_addr, d_in, wr_ptr_gray, full, wr_count, overflow
`ifdef FIFO_WR_ALMOST_FULL_EN
    , output almost_full
`endif
  );
endinterface

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of the asynchronous FIFO (write clock domain).
// Drives the SRAM write port, keeps binary/Gray write pointers, brings the
// Gray read pointer across with a two-flop synchroniser, and reports full,
// occupancy and sticky overflow. Occupancy and full are pessimistic: the
// read pointer seen here is always stale, so space is never overstated.
// Optional: define FIFO_WR_ALMOST_FULL_EN to add almost_full (threshold
// AFULL_THRESH words, same timing as wr_count).
module fifo_wr_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
`ifdef FIFO_WR_ALMOST_FULL_EN
  , parameter int AFULL_THRESH = 28
`endif
) (
  input  logic           wr_clk,
  input  logic           wr_rst,
  fifo_wr_ctrl_if.slave  bus
);

  localparam int PTR_W = ADDR_W + 1;
  typedef logic [PTR_W-1:0] ptr_t;

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PTR_W-1] = g[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic wr_en;
  ptr_t wr_bin_q, wr_bin_d;
  ptr_t wr_gray_q, wr_gray_d;
  ptr_t rq1_q, rq2_q, rq2_bin, full_pat;
  ptr_t count_q, count_d;
  logic full_q, full_d;
  logic overflow_q, overflow_d;
`ifdef FIFO_WR_ALMOST_FULL_EN
  logic afull_q, afull_d;
`endif

  // Accept decision and next-state for pointers and flags.
  // NOTE: every signal is assigned on every pass of always_comb, so no
  // latch can be inferred; keep it that way when adding branches.
  always_comb begin
    wr_en      = bus.wr_req & ~full_q & ~wr_rst;
    wr_bin_d   = wr_bin_q + ptr_t'(wr_en);
    wr_gray_d  = wr_bin_d ^ (wr_bin_d >> 1);
    rq2_bin    = gray2bin(rq2_q);
    // Write Gray equals read Gray with the top two bits inverted exactly
    // when the writer is one full lap (2**ADDR_W words) ahead.
    full_pat   = {~rq2_q[PTR_W-1:PTR_W-2], rq2_q[PTR_W-3:0]};
    full_d     = (wr_gray_d == full_pat);
    count_d    = wr_bin_d - rq2_bin;
    overflow_d = overflow_q | (bus.wr_req & full_q);
`ifdef FIFO_WR_ALMOST_FULL_EN
    afull_d    = (count_d >= ptr_t'(AFULL_THRESH));
`endif
  end

  // State registers, read-pointer synchroniser, synchronous reset.
  // NOTE: non-blocking assignments here so every flop samples the
  // pre-edge values; rq2 must see the old rq1, not the new one.
  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      wr_bin_q   <= '0;
      wr_gray_q  <= '0;
      rq1_q      <= '0;
      rq2_q      <= '0;
      full_q     <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
`ifdef FIFO_WR_ALMOST_FULL_EN
      afull_q    <= 1'b0;
`endif
    end else begin
      wr_bin_q   <= wr_bin_d;
      wr_gray_q  <= wr_gray_d;
      rq1_q      <= bus.rd_ptr_gray;
      rq2_q      <= rq1_q;
      full_q     <= full_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
`ifdef FIFO_WR_ALMOST_FULL_EN
      afull_q    <= afull_d;
`endif
    end
  end

  // SRAM write port: the word is captured on the same edge it is accepted.
  assign bus.wr_en       = wr_en;
  assign bus.wr_addr     = wr_bin_q[ADDR_W-1:0];
  assign bus.d_in        = bus.wr_data;
  assign bus.wr_ptr_gray = wr_gray_q;
  assign bus.full        = full_q;
  assign bus.wr_count    = count_q;
  assign bus.overflow    = overflow_q;
`ifdef FIFO_WR_ALMOST_FULL_EN
  assign bus.almost_full = afull_q;
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Self-checking bench for fifo_wr_ctrl: reset, fill, overflow, drain and
// refill (table-driven), pointer wrap, mid-operation reset and, when
// FIFO_WR_ALMOST_FULL_EN is defined, the almost-full threshold.
module tb_fifo_wr_ctrl;

  logic wr_clk = 1'b0;
  logic wr_rst;
  always #5 wr_clk = ~wr_clk;

  fifo_wr_ctrl_if bus ();

  fifo_wr_ctrl dut (
    .wr_clk (wr_clk),
    .wr_rst (wr_rst),
    .bus    (bus)
  );

  typedef struct {
    logic       req;
    logic [7:0] data;
    logic [5:0] rd;
    logic       en;
    logic       full;
    logic [5:0] cnt;
    logic       ovf;
    logic [5:0] ptr;
  } vec_t;

  typedef struct packed {
    logic [4:0] addr;
    logic [7:0] data;
  } wr_t;

  int         n_checks = 0;
  int         n_err    = 0;
  wr_t        sb_q[$];
  logic [4:0] m_addr;
  logic [7:0] sram_model [32];
  vec_t       tbl [9];

  function automatic logic [5:0] bin2gray(input logic [5:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One wr_clk cycle: drive inputs, check the write port at the falling
  // edge through the scoreboard, then step past the rising edge.
  task automatic step(input logic req, input logic [7:0] data,
                      input logic [5:0] rd, input logic exp_en);
    wr_t got;
    wr_t want;
    bus.wr_req      = req;
    bus.wr_data     = data;
    bus.rd_ptr_gray = rd;
    @(negedge wr_clk);
    check("wr_en", 32'(bus.wr_en), 32'(exp_en));
    if (exp_en) begin
      sb_q.push_back({m_addr, data});
      m_addr = m_addr + 5'd1;
    end
    if (bus.wr_en === 1'b1) begin
      check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        want = sb_q.pop_front();
        got  = {bus.wr_addr, bus.d_in};
        check("wr_addr", 32'(got.addr), 32'(want.addr));
        check("d_in", 32'(got.data), 32'(want.data));
      end
      sram_model[bus.wr_addr] = bus.d_in;
    end
    @(posedge wr_clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ptr"}, 32'(bus.wr_ptr_gray), 32'd0);
    check({tag, "_full"}, 32'(bus.full), 32'd0);
    check({tag, "_count"}, 32'(bus.wr_count), 32'd0);
    check({tag, "_ovf"}, 32'(bus.overflow), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [5:0] m_bin;
    logic [5:0] prev_ptr;
    logic       saw_wrap;

    // Overflow, drain via read pointer gray(4), then refill 4 words.
    tbl[0] = '{1'b1, 8'h55, 6'b000000, 1'b0, 1'b1, 6'd32, 1'b1, 6'b110000};
    tbl[1] = '{1'b0, 8'h00, 6'b000000, 1'b0, 1'b1, 6'd32, 1'b1, 6'b110000};
    tbl[2] = '{1'b0, 8'h00, 6'b000110, 1'b0, 1'b1, 6'd32, 1'b1, 6'b110000};
    tbl[3] = '{1'b0, 8'h00, 6'b000110, 1'b0, 1'b1, 6'd32, 1'b1, 6'b110000};
    tbl[4] = '{1'b0, 8'h00, 6'b000110, 1'b0, 1'b0, 6'd28, 1'b1, 6'b110000};
    tbl[5] = '{1'b1, 8'hA0, 6'b000110, 1'b1, 1'b0, 6'd29, 1'b1, 6'b110001};
    tbl[6] = '{1'b1, 8'hA1, 6'b000110, 1'b1, 1'b0, 6'd30, 1'b1, 6'b110011};
    tbl[7] = '{1'b1, 8'hA2, 6'b000110, 1'b1, 1'b0, 6'd31, 1'b1, 6'b110010};
    tbl[8] = '{1'b1, 8'hA3, 6'b000110, 1'b1, 1'b1, 6'd32, 1'b1, 6'b110110};

    for (int i = 0; i < 32; i++) sram_model[i] = 8'h00;
    m_addr          = '0;
    wr_rst          = 1'b1;
    bus.wr_req      = 1'b1;
    bus.wr_data     = 8'hFF;
    bus.rd_ptr_gray = '0;
    @(posedge wr_clk);
    #1;

    // Reset held two cycles with a pending request.
    step(1'b1, 8'hFF, 6'd0, 1'b0);
    step(1'b1, 8'hFF, 6'd0, 1'b0);
    check_zero("reset");
    wr_rst = 1'b0;

    // Fill 32 words back to back.
    for (int n = 1; n <= 32; n++) begin
      step(1'b1, 8'(n - 1), 6'd0, 1'b1);
      check("fill_count", 32'(bus.wr_count), 32'(n));
      check("fill_full", 32'(bus.full), 32'(n == 32));
    end
    check("fill_ptr", 32'(bus.wr_ptr_gray), 32'b110000);

    // Overflow, drain and refill from the table.
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].req, tbl[i].data, tbl[i].rd, tbl[i].en);
      check("tbl_full", 32'(bus.full), 32'(tbl[i].full));
      check("tbl_count", 32'(bus.wr_count), 32'(tbl[i].cnt));
      check("tbl_ovf", 32'(bus.overflow), 32'(tbl[i].ovf));
      check("tbl_ptr", 32'(bus.wr_ptr_gray), 32'(tbl[i].ptr));
      if (i == 1) check("sram0_kept", 32'(sram_model[0]), 32'h00);
    end
    check("sram0_refill", 32'(sram_model[0]), 32'hA0);
    check("sram3_refill", 32'(sram_model[3]), 32'hA3);

    // Wrap: read pointer kept 4 behind the write pointer after each push.
    m_bin = 6'd36;
    for (int k = 0; k < 4; k++) step(1'b0, 8'h00, bin2gray(6'd33), 1'b0);
    check("pre_wrap_full", 32'(bus.full), 32'd0);
    check("pre_wrap_count", 32'(bus.wr_count), 32'd3);
    saw_wrap = 1'b0;
    prev_ptr = bus.wr_ptr_gray;
    for (int n = 1; n <= 70; n++) begin
      step(1'b1, 8'(n + 8'h40), bin2gray(m_bin + 6'd1 - 6'd4), 1'b1);
      m_bin = m_bin + 6'd1;
      check("wrap_full", 32'(bus.full), 32'd0);
      check("wrap_count_le6", 32'(bus.wr_count <= 6'd6), 32'd1);
      check("wrap_ptr", 32'(bus.wr_ptr_gray), 32'(bin2gray(m_bin)));
      if (prev_ptr == 6'b100000 && bus.wr_ptr_gray == 6'b000000) saw_wrap = 1'b1;
      prev_ptr = bus.wr_ptr_gray;
    end
    check("wrap_seen", 32'(saw_wrap), 32'd1);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    // Reset mid-operation with a request pending.
    wr_rst = 1'b1;
    step(1'b1, 8'h77, bin2gray(m_bin), 1'b0);
    check_zero("midrst");
    wr_rst = 1'b0;
    m_addr = '0;
    sb_q.delete();

`ifdef FIFO_WR_ALMOST_FULL_EN
    // Almost-full threshold at 28 words.
    step(1'b0, 8'h00, 6'd0, 1'b0);
    step(1'b0, 8'h00, 6'd0, 1'b0);
    for (int n = 1; n <= 28; n++) begin
      step(1'b1, 8'(n), 6'd0, 1'b1);
      if (n == 27) check("afull_27", 32'(bus.almost_full), 32'd0);
      if (n == 28) check("afull_28", 32'(bus.almost_full), 32'd1);
    end
`endif

    bus.wr_req = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_ctrl.md
Name: fifo_wr_ctrl

Overview:
Write-side controller for the asynchronous FIFO, in the write clock domain. It drives the write port of the 32x8 dual-port SRAM (wr_en, wr_addr, d_in). It maintains the binary and Gray write pointers and synchronises the read pointer from the read domain. It produces the full, occupancy and sticky overflow flags for the upstream producer.

Parameters:
ADDR_W, 5, SRAM address width; FIFO depth = 2**ADDR_W (32).
DATA_W, 8, data width, matching the SRAM word.
AFULL_THRESH, 28, almost-full threshold in words; used only with the optional feature.

Ports:
wr_clk  input  1  write-domain clock; all state updates on its rising edge.
wr_rst  input  1  synchronous, active-high reset.
wr_req  input  1  producer push request for this cycle.
wr_data  input  DATA_W  producer data.
rd_ptr_gray  input  ADDR_W+1  Gray-coded read pointer from the read domain; asynchronous to wr_clk.
wr_en  output  1  SRAM write enable.
wr_addr  output  ADDR_W  SRAM write address.
d_in  output  DATA_W  SRAM write data.
wr_ptr_gray  output  ADDR_W+1  registered Gray write pointer, sent to the read domain.
full  output  1  registered; FIFO holds 2**ADDR_W words.
wr_count  output  ADDR_W+1  registered occupancy as seen from the write domain.
overflow  output  1  sticky; a push was attempted while full.

Behaviour:
- Reset values: all registers are 0, so wr_ptr_gray=0, full=0, wr_count=0, overflow=0, and both synchroniser flops are 0.
- Write enable and data path:
  - wr_en = wr_req & ~full & ~wr_rst, combinational.
  - wr_addr = wr_bin[ADDR_W-1:0].
  - d_in = wr_data, pass-through.
  - The SRAM captures the word on the same wr_clk edge, so accept-to-store latency is 0 cycles.
- Pointers: wr_bin (ADDR_W+1 bits) and wr_gray are registers.
  - wr_bin_next = wr_bin + wr_en, modulo 2**(ADDR_W+1).
  - wr_gray <= wr_bin_next ^ (wr_bin_next >> 1).
  - wr_ptr_gray = wr_gray, registered only, never combinational.
- Read-pointer synchroniser: two flops, rq1 <= rd_ptr_gray and rq2 <= rq1. No logic between the flops. Only rq2 is used.
- Full flag:
  - full <= (gray(wr_bin_next) == {~rq2[ADDR_W:ADDR_W-1], rq2[ADDR_W-2:0]}).
  - full asserts on the edge that accepts the 32nd unread word.
  - full deasserts on the 3rd wr_clk edge after rd_ptr_gray changes (2 sync edges + 1 register edge). This is pessimistic by design.
- Occupancy: wr_count <= wr_bin_next - gray2bin(rq2), modulo 2**(ADDR_W+1). It never exceeds 2**ADDR_W. It may overstate occupancy, never understate it.
- Overflow: overflow <= 1 when wr_req & full; cleared only by wr_rst. A rejected push leaves wr_bin, wr_gray and the SRAM unchanged.
- Wrap-around: wr_addr wraps 31->0. wr_bin wraps 63->0 and the Gray pointer wraps 100000->000000; full detection stays correct across both wraps.
- Simultaneous push and read-pointer update: the push is judged against the current full only; the new read pointer takes effect after synchronisation.
- Reset mid-operation: every register returns to 0 on the next edge and wr_en is forced to 0 during reset. The read domain must be reset in the same window; stale synchroniser contents are discarded.

Optional Feature:
FIFO_WR_ALMOST_FULL_EN
- Defined: adds output almost_full (1 bit, reset 0).
  - almost_full <= (wr_bin_next - gray2bin(rq2)) >= AFULL_THRESH.
  - It uses the same timing as wr_count.
- Not defined: the almost_full port and its logic are absent, and AFULL_THRESH is unused.

Test Plan:
1. Reset: hold wr_rst for 2 cycles with wr_req=1 -> wr_en=0 throughout; after release wr_ptr_gray=0, full=0, wr_count=0, overflow=0.
2. Fill: rd_ptr_gray=0, 32 back-to-back pushes of data 0x00..0x1F -> wr_addr steps 0..31; full=1 after the 32nd edge; wr_count=32; wr_ptr_gray=6'b110000.
3. Overflow: while full, drive wr_req=1 with 0x55 -> wr_en=0; overflow=1 on the next edge and stays 1; wr_ptr_gray unchanged; SRAM word 0 still 0x00.
4. Drain and refill: from the full state, set rd_ptr_gray=6'b000110 (gray 4) -> full=0 and wr_count=28 on the 3rd edge. Then 4 pushes -> addresses 0..3, full=1, wr_ptr_gray=6'b110110.
5. Wrap: with rd_ptr_gray tracking 4 words behind, run 70 continuous pushes -> wr_ptr_gray passes 100000->000000; full never asserts; wr_count stays at or below 6 throughout.
6. Optional (macro defined, AFULL_THRESH=28): rd_ptr_gray=0, push 28 words -> almost_full=1 after the 28th edge; after 27 pushes it is 0. Macro undefined -> the design elaborates without the almost_full port.
